seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for a common-anode multi-digit 7-segment display.
// One shared hex decoder is fed through `digit`, and each digit has its own
// active-low anode. A value loaded here is held in a pending buffer. It reaches
// the display register only at a frame boundary (or straight away while the
// scan is off), so a digit never shows a mix of old and new data.
// Optional feature: define SEG_LZ_BLANK_EN to turn on leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int TICKS  = 50000,
  parameter int GUARD  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  pending,
  output logic                  commit,
  output logic                  frame,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            digit,
  output logic                  dp
);

  localparam int PTR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (TICKS > GUARD) ? ((TICKS > 2) ? TICKS : 2)
                                           : ((GUARD > 2) ? GUARD : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                state;
  logic [PTR_W-1:0]      ptr;
  logic [CNT_W-1:0]      cnt;

  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic [4*DIGITS-1:0]   disp_val;
  logic [DIGITS-1:0]     disp_dp;

  logic                  wrap_now;
  logic                  commit_now;
  logic [DIGITS-1:0]     sel;
  logic [DIGITS-1:0]     blank;

  // The last drive cycle of the last digit closes the frame. A pending value
  // is committed there, or at once whenever the scan is off.
  assign wrap_now   = en && (state == ST_DRIVE) && (cnt == TICK_LAST) && (ptr == PTR_LAST);
  assign commit_now = pending && (wrap_now || (state == ST_OFF));
  assign sel        = DIGITS'(1) << ptr;

`ifdef SEG_LZ_BLANK_EN
  // A digit above digit 0 stays dark when it and every digit above it hold
  // zero and its own decimal point is off.
  always_comb begin
    logic upper_zero;
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (disp_val[4*k +: 4] == 4'd0);
      blank[k]   = upper_zero & ~disp_dp[k];
    end
  end
`else
  assign blank = '0;
`endif

  // Scan sequencer: OFF -> (GUARD ->) DRIVE for each digit in turn, wrapping every frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      ptr   <= '0;
      cnt   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= wrap_now;
      if (!en) begin
        state <= ST_OFF;
        ptr   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            ptr   <= '0;
            cnt   <= '0;
            state <= (GUARD == 0) ? ST_DRIVE : ST_GUARD;
          end
          ST_GUARD: begin
            if (cnt == GUARD_LAST) begin
              cnt   <= '0;
              state <= ST_DRIVE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DRIVE: begin
            if (cnt == TICK_LAST) begin
              cnt   <= '0;
              ptr   <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
              state <= (GUARD == 0) ? ST_DRIVE : ST_GUARD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_OFF;
            ptr   <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Double buffer: the newest load waits in pend_*. The display register only changes on a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      pending  <= 1'b0;
      commit   <= 1'b0;
    end else begin
      commit <= commit_now;
      if (commit_now) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      if (load) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end else if (commit_now) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered pin drive. During GUARD the anodes stay off while the decoder already sees the next digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an    <= '1;
      digit <= 4'd0;
      dp    <= 1'b1;
    end else begin
      an    <= ((state == ST_DRIVE) && !blank[ptr]) ? ~sel : '1;
      digit <= disp_val[{ptr, 2'b00} +: 4];
      dp    <= ~disp_dp[ptr];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=4, TICKS=4, GUARD=2). The reference model
// works out the display schedule from the number of cycles since the scan was
// enabled. A monitor compares the DUT pins against the queued expectations.
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int T = 4;
  localparam int G = 2;
  localparam int S = G + T;
  localparam int P = D * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        pending, commit, frame, dp;
  logic [3:0]  an, digit;

  seg_scan_ctrl #(.DIGITS(D), .TICKS(T), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
    .pending(pending), .commit(commit), .frame(frame), .an(an), .digit(digit), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] digit;
    logic       dp;
    logic       pending;
    logic       commit;
    logic       frame;
  } obs_t;

  obs_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  int          m_e = 0;
  logic [15:0] m_pend_v = '0, m_disp_v = '0;
  logic [3:0]  m_pend_d = '0, m_disp_d = '0;
  bit          m_pend_f = 0;

  function automatic bit blank_f(input int slot, input logic [15:0] v, input logic [3:0] d);
`ifdef SEG_LZ_BLANK_EN
    return (slot > 0) && ((v >> (4 * slot)) == 16'd0) && !d[slot];
`else
    return 1'b0;
`endif
  endfunction

  // Pins seen after an edge, given the number of enabled cycles e before that edge.
  function automatic void view(input int e, input logic [15:0] v, input logic [3:0] d,
                               output logic [3:0] an_o, output logic [3:0] dg_o, output logic dp_o);
    int p;
    int slot;
    bit driven;
    slot   = 0;
    driven = 0;
    if (e > 0) begin
      p      = (e - 1) % P;
      slot   = p / S;
      driven = (p % S) >= G;
    end
    an_o = (driven && !blank_f(slot, v, d)) ? ~(4'b0001 << slot) : 4'hF;
    dg_o = v[4*slot +: 4];
    dp_o = ~d[slot];
  endfunction

  // Reference model: one expectation per clock edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_e = 0; m_pend_v = '0; m_disp_v = '0; m_pend_d = '0; m_disp_d = '0; m_pend_f = 0;
        exp_q.delete();
      end else begin
        obs_t x;
        int   e_new;
        bit   wrap, doc;
        view(m_e, m_disp_v, m_disp_d, x.an, x.digit, x.dp);
        e_new = en ? m_e + 1 : 0;
        wrap  = (e_new >= 2) && (((e_new - 1) % P) == 0);
        doc   = m_pend_f && (wrap || (m_e == 0));
        if (doc) begin
          m_disp_v = m_pend_v;
          m_disp_d = m_pend_d;
        end
        if (load) begin
          m_pend_v = value_in;
          m_pend_d = dp_in;
          m_pend_f = 1;
        end else if (doc) begin
          m_pend_f = 0;
        end
        x.pending = m_pend_f;
        x.commit  = doc;
        x.frame   = wrap;
        m_e = e_new;
        exp_q.push_back(x);
      end
    end
  end

  // Monitor: compare pins mid-cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        obs_t x, g;
        x = exp_q.pop_front();
        g = {an, digit, dp, pending, commit, frame};
        checks++;
        if (g !== x) begin
          errors++;
          $display("FAIL pins t=%0t got an=%b digit=%h dp=%b pending=%b commit=%b frame=%b expected an=%b digit=%h dp=%b pending=%b commit=%b frame=%b",
                   $time, g.an, g.digit, g.dp, g.pending, g.commit, g.frame,
                   x.an, x.digit, x.dp, x.pending, x.commit, x.frame);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    tick(1);
    load     = 1'b0;
  endtask

  task automatic wait_phase(input int target);
    int n;
    n = 0;
    while (!(m_e > 0 && (m_e % P) == target)) begin
      tick(1);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL wait_phase got timeout required phase %0d", target);
        return;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, want);
    end
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Load while off: commits immediately
    do_load(16'h1357, 4'b0010);
    tick(4);

    // Enable and load 12AF: shown after the first wrap
    en = 1'b1;
    do_load(16'h12AF, 4'b0000);
    tick(3 * P);

    // Two loads inside one frame: newest wins
    wait_phase(3);
    do_load(16'h0001, 4'b0000);
    tick(5);
    do_load(16'h0002, 4'b0000);
    tick(2 * P);

    // Load on the wrap edge itself
    wait_phase(5);
    do_load(16'h5678, 4'b1000);
    wait_phase(0);
    do_load(16'h9ABC, 4'b0001);
    tick(2 * P);

    // Value with leading zeros
    do_load(16'h0030, 4'b0000);
    tick(2 * P);

    // Drop enable mid-drive, then restart
    wait_phase(4);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(2 * P);

    // Randomized enable and loads
    for (int i = 0; i < 800; i++) begin
      if (en) begin
        if ($urandom_range(0, 149) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 4) == 0) en = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        value_in = 16'($urandom);
        dp_in    = 4'($urandom);
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick(1);
    end
    load = 1'b0;

    // Asynchronous reset mid-drive with a value pending
    en = 1'b1;
    do_load(16'hFFFF, 4'hF);
    tick(2 * P);
    wait_phase(9);
    do_load(16'h4321, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_an", {4'b0, an}, 8'h0F);
    chk("reset_digit", {4'b0, digit}, 8'h00);
    chk("reset_dp", {7'b0, dp}, 8'h01);
    chk("reset_pending", {7'b0, pending}, 8'h00);
    chk("reset_commit", {7'b0, commit}, 8'h00);
    chk("reset_frame", {7'b0, frame}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(P + 3);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        value_in = 16'($urandom);
        dp_in    = 4'($urandom);
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick(1);
    end
    load = 1'b0;
    en   = 1'b0;
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
